// File: rtl/i2s_codec_slave.sv
// Codec-side I2S slave: oversamples bclk/lrc/data in the clk domain, deserialises DAC pairs
// and serialises ADC pairs with the standard one-bit delay after each lrc edge.
module i2s_codec_slave #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i2s_bclk,
    input  logic          i2s_daclrc,
    input  logic          i2s_dacdat,
    input  logic          i2s_adclrc,
    output logic          i2s_adcdat,
    output logic          dac_vld,
    output logic [DW-1:0] dac_l,
    output logic [DW-1:0] dac_r,
    output logic          adc_req,
    input  logic [DW-1:0] adc_l,
    input  logic [DW-1:0] adc_r
);

    localparam int unsigned CW = $clog2(DW + 1);
    localparam logic [CW-1:0] CntIdle = CW'(DW);
    localparam logic [CW-1:0] CntLast = CW'(DW - 1);

    logic [2:0]    bclk_sync_q, bclk_sync_d;
    logic [1:0]    dlrc_sync_q, dlrc_sync_d;
    logic [1:0]    alrc_sync_q, alrc_sync_d;
    logic [1:0]    ddat_sync_q, ddat_sync_d;

    logic          rx_lrc_prev_q, rx_lrc_prev_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [DW-1:0] rx_sh_q, rx_sh_d;
    logic [DW-1:0] left_hold_q, left_hold_d;
    logic          left_ok_q, left_ok_d;
    logic [DW-1:0] dac_l_q, dac_l_d;
    logic [DW-1:0] dac_r_q, dac_r_d;
    logic          dac_vld_q, dac_vld_d;

    logic          tx_lrc_prev_q, tx_lrc_prev_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [DW-1:0] tx_sh_q, tx_sh_d;
    logic [DW-1:0] r_hold_q, r_hold_d;
    logic          tx_started_q, tx_started_d;
    logic          adcdat_q, adcdat_d;
    logic          adc_req_q, adc_req_d;

    logic          bclk_rise, bclk_fall;
    logic          dlrc_s, alrc_s, ddat_s;
    logic [DW-1:0] rx_word;

    assign bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
    assign bclk_fall = ~bclk_sync_q[1] & bclk_sync_q[2];
    assign dlrc_s    = dlrc_sync_q[1];
    assign alrc_s    = alrc_sync_q[1];
    assign ddat_s    = ddat_sync_q[1];
    assign rx_word   = {rx_sh_q[DW-2:0], ddat_s};

    always_comb begin
        bclk_sync_d   = {bclk_sync_q[1:0], i2s_bclk};
        dlrc_sync_d   = {dlrc_sync_q[0], i2s_daclrc};
        alrc_sync_d   = {alrc_sync_q[0], i2s_adclrc};
        ddat_sync_d   = {ddat_sync_q[0], i2s_dacdat};

        rx_lrc_prev_d = rx_lrc_prev_q;
        rx_cnt_d      = rx_cnt_q;
        rx_sh_d       = rx_sh_q;
        left_hold_d   = left_hold_q;
        left_ok_d     = left_ok_q;
        dac_l_d       = dac_l_q;
        dac_r_d       = dac_r_q;
        dac_vld_d     = 1'b0;

        tx_lrc_prev_d = tx_lrc_prev_q;
        tx_cnt_d      = tx_cnt_q;
        tx_sh_d       = tx_sh_q;
        r_hold_d      = r_hold_q;
        tx_started_d  = tx_started_q;
        adcdat_d      = adcdat_q;
        adc_req_d     = 1'b0;

        if (bclk_rise) begin
            if (dlrc_s != rx_lrc_prev_q) begin
                rx_lrc_prev_d = dlrc_s;
                rx_cnt_d      = '0;
                // A new left channel invalidates any left word left over from a broken frame.
                if (!dlrc_s) begin
                    left_ok_d = 1'b0;
                end
            end else if (rx_cnt_q < CntIdle) begin
                rx_sh_d  = rx_word;
                rx_cnt_d = rx_cnt_q + CW'(1);
                if (rx_cnt_q == CntLast) begin
                    if (!dlrc_s) begin
                        left_hold_d = rx_word;
                        left_ok_d   = 1'b1;
                    end else if (left_ok_q) begin
                        dac_l_d   = left_hold_q;
                        dac_r_d   = rx_word;
                        dac_vld_d = 1'b1;
                        left_ok_d = 1'b0;
                    end
                end
            end
        end

        if (bclk_fall) begin
            if (alrc_s != tx_lrc_prev_q) begin
                tx_lrc_prev_d = alrc_s;
                adcdat_d      = 1'b0;
                if (!alrc_s) begin
                    tx_sh_d      = adc_l;
                    r_hold_d     = adc_r;
                    adc_req_d    = 1'b1;
                    tx_cnt_d     = '0;
                    tx_started_d = 1'b1;
                end else if (tx_started_q) begin
                    tx_sh_d  = r_hold_q;
                    tx_cnt_d = '0;
                end
            end else if (tx_cnt_q < CntIdle) begin
                adcdat_d = tx_sh_q[DW-1];
                tx_sh_d  = {tx_sh_q[DW-2:0], 1'b0};
                tx_cnt_d = tx_cnt_q + CW'(1);
            end else begin
                adcdat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync_q   <= '0;
            dlrc_sync_q   <= '1;
            alrc_sync_q   <= '1;
            ddat_sync_q   <= '0;
            rx_lrc_prev_q <= 1'b1;
            rx_cnt_q      <= CntIdle;
            rx_sh_q       <= '0;
            left_hold_q   <= '0;
            left_ok_q     <= 1'b0;
            dac_l_q       <= '0;
            dac_r_q       <= '0;
            dac_vld_q     <= 1'b0;
            tx_lrc_prev_q <= 1'b1;
            tx_cnt_q      <= CntIdle;
            tx_sh_q       <= '0;
            r_hold_q      <= '0;
            tx_started_q  <= 1'b0;
            adcdat_q      <= 1'b0;
            adc_req_q     <= 1'b0;
        end else begin
            bclk_sync_q   <= bclk_sync_d;
            dlrc_sync_q   <= dlrc_sync_d;
            alrc_sync_q   <= alrc_sync_d;
            ddat_sync_q   <= ddat_sync_d;
            rx_lrc_prev_q <= rx_lrc_prev_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_sh_q       <= rx_sh_d;
            left_hold_q   <= left_hold_d;
            left_ok_q     <= left_ok_d;
            dac_l_q       <= dac_l_d;
            dac_r_q       <= dac_r_d;
            dac_vld_q     <= dac_vld_d;
            tx_lrc_prev_q <= tx_lrc_prev_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_sh_q       <= tx_sh_d;
            r_hold_q      <= r_hold_d;
            tx_started_q  <= tx_started_d;
            adcdat_q      <= adcdat_d;
            adc_req_q     <= adc_req_d;
        end
    end

    assign i2s_adcdat = adcdat_q;
    assign dac_vld    = dac_vld_q;
    assign dac_l      = dac_l_q;
    assign dac_r      = dac_r_q;
    assign adc_req    = adc_req_q;

endmodule

// File: tb/tb_i2s_codec_slave.sv
// Bench for i2s_codec_slave: behaves as an I2S master with bclk = clk/8, 32-bit slots.
module tb_i2s_codec_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        i2s_bclk, i2s_daclrc, i2s_dacdat, i2s_adclrc;
    logic        i2s_adcdat;
    logic        dac_vld, adc_req;
    logic [15:0] dac_l, dac_r, adc_l, adc_r;
    logic [15:0] adc_l_drv, adc_r_drv;
    logic        loop_en;

    int total = 0;
    int bad   = 0;
    int vld_cnt = 0;
    int req_cnt = 0;

    always #5 clk = ~clk;

    assign adc_l = loop_en ? dac_l : adc_l_drv;
    assign adc_r = loop_en ? dac_r : adc_r_drv;

    i2s_codec_slave #(.DW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .i2s_bclk   (i2s_bclk),
        .i2s_daclrc (i2s_daclrc),
        .i2s_dacdat (i2s_dacdat),
        .i2s_adclrc (i2s_adclrc),
        .i2s_adcdat (i2s_adcdat),
        .dac_vld    (dac_vld),
        .dac_l      (dac_l),
        .dac_r      (dac_r),
        .adc_req    (adc_req),
        .adc_l      (adc_l),
        .adc_r      (adc_r)
    );

    always @(negedge clk) begin
        if (dac_vld) vld_cnt <= vld_cnt + 1;
        if (adc_req) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drives bit slots k0..k1-1 of one channel; k=0 is the delay slot, k=1..16 carry the word.
    task automatic slot(input logic lrc, input logic [15:0] word, input int k0, input int k1,
                        output logic [15:0] cap, output logic pad_ok);
        logic b;
        cap    = '0;
        pad_ok = 1'b1;
        for (int k = k0; k < k1; k++) begin
            @(negedge clk);
            i2s_bclk   = 1'b0;
            i2s_daclrc = lrc;
            i2s_adclrc = lrc;
            i2s_dacdat = (k >= 1 && k <= 16) ? word[16-k] : 1'b0;
            repeat (3) @(negedge clk);
            @(negedge clk);
            b        = i2s_adcdat;
            i2s_bclk = 1'b1;
            if (k >= 1 && k <= 16) cap = {cap[14:0], b};
            else if (b) pad_ok = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r, input int llen,
                         output logic [15:0] cl, output logic [15:0] cr, output logic pad_ok);
        logic p0, p1;
        slot(1'b0, l, 0, llen, cl, p0);
        slot(1'b1, r, 0, 32, cr, p1);
        pad_ok = p0 & p1;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int          llen;
        logic [15:0] dl, dr, al, ar;
        int          ev;
        logic [15:0] edl, edr, ecl, ecr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] cl, cr;
        logic        pad;
        int          v0, r0;
        logic [15:0] ll[5], lr[5];

        vecs[0] = '{32, 16'hDEAB, 16'hDEAC, 16'hA5C3, 16'h0F0F, 1,
                    16'hDEAB, 16'hDEAC, 16'hA5C3, 16'h0F0F};
        vecs[1] = '{32, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 1,
                    16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[2] = '{32, 16'h8001, 16'h7FFE, 16'h0001, 16'h8000, 1,
                    16'h8001, 16'h7FFE, 16'h0001, 16'h8000};
        // 8-bit left channel: no frame, outputs keep the previous pair; master sees 8 bits only.
        vecs[3] = '{9, 16'h1234, 16'h5678, 16'hC35A, 16'h9669, 0,
                    16'h8001, 16'h7FFE, 16'h00C3, 16'h9669};
        vecs[4] = '{32, 16'h1357, 16'h2468, 16'h5AA5, 16'h3CC3, 1,
                    16'h1357, 16'h2468, 16'h5AA5, 16'h3CC3};

        rst        = 1'b1;
        i2s_bclk   = 1'b0;
        i2s_daclrc = 1'b1;
        i2s_adclrc = 1'b1;
        i2s_dacdat = 1'b0;
        loop_en    = 1'b0;
        adc_l_drv  = '0;
        adc_r_drv  = '0;
        repeat (5) @(negedge clk);
        chk("rst_adcdat", 32'(i2s_adcdat), 32'h0);
        chk("rst_dac_vld", 32'(dac_vld), 32'h0);
        chk("rst_dac_l", 32'(dac_l), 32'h0);
        chk("rst_dac_r", 32'(dac_r), 32'h0);
        chk("rst_adc_req", 32'(adc_req), 32'h0);
        rst = 1'b0;
        slot(1'b1, 16'h0, 0, 4, cl, pad);

        for (int i = 0; i < 5; i++) begin
            adc_l_drv = vecs[i].al;
            adc_r_drv = vecs[i].ar;
            v0 = vld_cnt;
            r0 = req_cnt;
            frame(vecs[i].dl, vecs[i].dr, vecs[i].llen, cl, cr, pad);
            chk($sformatf("v%0d_vld_cnt", i), 32'(vld_cnt - v0), 32'(vecs[i].ev));
            chk($sformatf("v%0d_dac_l", i), 32'(dac_l), 32'(vecs[i].edl));
            chk($sformatf("v%0d_dac_r", i), 32'(dac_r), 32'(vecs[i].edr));
            chk($sformatf("v%0d_adc_cap_l", i), 32'(cl), 32'(vecs[i].ecl));
            chk($sformatf("v%0d_adc_cap_r", i), 32'(cr), 32'(vecs[i].ecr));
            chk($sformatf("v%0d_req_cnt", i), 32'(req_cnt - r0), 32'h1);
            chk($sformatf("v%0d_pad_zero", i), 32'(pad), 32'h1);
        end

        // Loopback: each ADC frame carries the DAC pair received in the previous frame.
        loop_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ll[i] = 16'h1111 * 16'(i + 1);
            lr[i] = ~ll[i];
            frame(ll[i], lr[i], 32, cl, cr, pad);
            chk($sformatf("loop%0d_cap_l", i), 32'(cl), (i == 0) ? 32'h1357 : 32'(ll[i-1]));
            chk($sformatf("loop%0d_cap_r", i), 32'(cr), (i == 0) ? 32'h2468 : 32'(lr[i-1]));
        end
        loop_en = 1'b0;

        // Reset released in the middle of a right word: nothing until a full new pair.
        adc_l_drv = 16'h3C3C;
        adc_r_drv = 16'hC3C3;
        slot(1'b0, 16'hAAAA, 0, 32, cl, pad);
        slot(1'b1, 16'h5555, 0, 10, cl, pad);
        rst_pulse();
        chk("midr_rst_vld", 32'(dac_vld), 32'h0);
        chk("midr_rst_dac_l", 32'(dac_l), 32'h0);
        chk("midr_rst_dac_r", 32'(dac_r), 32'h0);
        v0 = vld_cnt;
        slot(1'b1, 16'h5555, 10, 32, cl, pad);
        chk("midr_no_stale_vld", 32'(vld_cnt - v0), 32'h0);
        r0 = req_cnt;
        frame(16'h1111, 16'h2222, 32, cl, cr, pad);
        chk("midr_vld_cnt", 32'(vld_cnt - v0), 32'h1);
        chk("midr_dac_l", 32'(dac_l), 32'h1111);
        chk("midr_dac_r", 32'(dac_r), 32'h2222);
        chk("midr_req_cnt", 32'(req_cnt - r0), 32'h1);
        chk("midr_cap_l", 32'(cl), 32'h3C3C);
        chk("midr_cap_r", 32'(cr), 32'hC3C3);

        // One-clk reset while transmitting all-ones: adcdat drops at once, next frame is clean.
        adc_l_drv = 16'hFFFF;
        adc_r_drv = 16'hFFFF;
        slot(1'b0, 16'h0, 0, 8, cl, pad);
        chk("midtx_adcdat_pre", 32'(i2s_adcdat), 32'h1);
        rst_pulse();
        chk("midtx_adcdat_post", 32'(i2s_adcdat), 32'h0);
        slot(1'b0, 16'h0, 8, 32, cl, pad);
        slot(1'b1, 16'h0, 0, 32, cl, pad);
        adc_l_drv = 16'hA5C3;
        adc_r_drv = 16'h0F0F;
        frame(16'hBEEF, 16'hCAFE, 32, cl, cr, pad);
        chk("midtx_cap_l", 32'(cl), 32'hA5C3);
        chk("midtx_cap_r", 32'(cr), 32'h0F0F);
        chk("midtx_pad_zero", 32'(pad), 32'h1);
        chk("midtx_dac_l", 32'(dac_l), 32'hBEEF);
        chk("midtx_dac_r", 32'(dac_r), 32'hCAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
